// File: rtl/ldst_control_unit.sv
// Hardwired Moore control unit sequencing fetch plus ld/st (and optional ldi) steps.
// Optional feature macro: CU_LDI_EN enables the ldi (opcode 00001) instruction.
module ldst_control_unit (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic [4:0] opcode,
    output logic       PCout,
    output logic       ZLowout,
    output logic       MDRout,
    output logic       BAout,
    output logic       Cout,
    output logic       R_out,
    output logic       MARin,
    output logic       MDRin,
    output logic       PCin,
    output logic       IRin,
    output logic       Yin,
    output logic       ZHighIn,
    output logic       ZLowIn,
    output logic       R_in,
    output logic       IncPC,
    output logic       Read,
    output logic       RAM_write_en,
    output logic       alu_add,
    output logic       GRA,
    output logic       GRB,
    output logic       GRC,
    output logic [3:0] state,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd15
    } state_e;

    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_ST  = 5'b00010;
`ifdef CU_LDI_EN
    localparam logic [4:0] OP_LDI = 5'b00001;
`endif

    state_e     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic       halted_q, halted_d;
    logic       op_legal;
    logic       is_st;
    logic       is_ldi;

    // Legality is judged on the live opcode, since op_q is only loaded leaving T3.
    always_comb begin
`ifdef CU_LDI_EN
        op_legal = (opcode == OP_LD) || (opcode == OP_ST) || (opcode == OP_LDI);
        is_ldi   = (op_q == OP_LDI);
`else
        op_legal = (opcode == OP_LD) || (opcode == OP_ST);
        is_ldi   = 1'b0;
`endif
        is_st    = (op_q == OP_ST);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        halted_d = halted_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                op_d = opcode;
                if (op_legal) begin
                    state_d = S_T4;
                end else begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end
            end
            S_T4:   state_d = S_T5;
            S_T5: begin
                if (is_ldi) state_d = run ? S_T0 : S_IDLE;
                else        state_d = S_T6;
            end
            S_T6:   state_d = S_T7;
            S_T7:   state_d = run ? S_T0 : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            op_q     <= 5'b00000;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        PCout        = 1'b0;
        ZLowout      = 1'b0;
        MDRout       = 1'b0;
        BAout        = 1'b0;
        Cout         = 1'b0;
        R_out        = 1'b0;
        MARin        = 1'b0;
        MDRin        = 1'b0;
        PCin         = 1'b0;
        IRin         = 1'b0;
        Yin          = 1'b0;
        ZHighIn      = 1'b0;
        ZLowIn       = 1'b0;
        R_in         = 1'b0;
        IncPC        = 1'b0;
        Read         = 1'b0;
        RAM_write_en = 1'b0;
        alu_add      = 1'b0;
        GRA          = 1'b0;
        GRB          = 1'b0;
        GRC          = 1'b0;
        case (state_q)
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                ZHighIn = 1'b1;
                ZLowIn  = 1'b1;
            end
            S_T1: begin
                ZLowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                GRB   = 1'b1;
                BAout = 1'b1;
                Yin   = 1'b1;
            end
            S_T4: begin
                Cout    = 1'b1;
                alu_add = 1'b1;
                ZHighIn = 1'b1;
                ZLowIn  = 1'b1;
            end
            S_T5: begin
                ZLowout = 1'b1;
                if (is_ldi) begin
                    GRA  = 1'b1;
                    R_in = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (is_st) begin
                    GRA   = 1'b1;
                    R_out = 1'b1;
                end else begin
                    Read = 1'b1;
                end
            end
            S_T7: begin
                if (is_st) begin
                    RAM_write_en = 1'b1;
                end else begin
                    MDRout = 1'b1;
                    GRA    = 1'b1;
                    R_in   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign state  = state_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_ldst_control_unit.sv
// Directed bench for ldst_control_unit: fetch, ld, st, ldi, trap and reset cases.
// Build with +define+CU_LDI_EN to exercise the ldi variant.
module tb_ldst_control_unit;

    logic       clk;
    logic       clr;
    logic       run;
    logic [4:0] opcode;
    logic       PCout, ZLowout, MDRout, BAout, Cout, R_out;
    logic       MARin, MDRin, PCin, IRin, Yin, ZHighIn, ZLowIn, R_in;
    logic       IncPC, Read, RAM_write_en, alu_add;
    logic       GRA, GRB, GRC;
    logic [3:0] state;
    logic       halted;
    logic [20:0] ctl;

    int tests;
    int fails;

    localparam logic [20:0] PCO  = 21'h1 << 20;
    localparam logic [20:0] ZLO  = 21'h1 << 19;
    localparam logic [20:0] MDRO = 21'h1 << 18;
    localparam logic [20:0] BAO  = 21'h1 << 17;
    localparam logic [20:0] CO   = 21'h1 << 16;
    localparam logic [20:0] ROUT = 21'h1 << 15;
    localparam logic [20:0] MARI = 21'h1 << 14;
    localparam logic [20:0] MDRI = 21'h1 << 13;
    localparam logic [20:0] PCI  = 21'h1 << 12;
    localparam logic [20:0] IRI  = 21'h1 << 11;
    localparam logic [20:0] YI   = 21'h1 << 10;
    localparam logic [20:0] ZHI  = 21'h1 << 9;
    localparam logic [20:0] ZLI  = 21'h1 << 8;
    localparam logic [20:0] RI   = 21'h1 << 7;
    localparam logic [20:0] INC  = 21'h1 << 6;
    localparam logic [20:0] RD   = 21'h1 << 5;
    localparam logic [20:0] WE   = 21'h1 << 4;
    localparam logic [20:0] ADD  = 21'h1 << 3;
    localparam logic [20:0] GA   = 21'h1 << 2;
    localparam logic [20:0] GB   = 21'h1 << 1;

    localparam logic [20:0] C_T0 = PCO | MARI | INC | ZHI | ZLI;
    localparam logic [20:0] C_T1 = ZLO | PCI | RD | MDRI;
    localparam logic [20:0] C_T2 = MDRO | IRI;
    localparam logic [20:0] C_T3 = GB | BAO | YI;
    localparam logic [20:0] C_T4 = CO | ADD | ZHI | ZLI;
    localparam logic [20:0] C_T5M = ZLO | MARI;
    localparam logic [20:0] C_T5I = ZLO | GA | RI;
    localparam logic [20:0] C_T6L = RD | MDRI;
    localparam logic [20:0] C_T7L = MDRO | GA | RI;
    localparam logic [20:0] C_T6S = GA | ROUT | MDRI;
    localparam logic [20:0] C_T7S = WE;

    ldst_control_unit dut (
        .clk(clk), .clr(clr), .run(run), .opcode(opcode),
        .PCout(PCout), .ZLowout(ZLowout), .MDRout(MDRout),
        .BAout(BAout), .Cout(Cout), .R_out(R_out),
        .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IRin(IRin),
        .Yin(Yin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .R_in(R_in),
        .IncPC(IncPC), .Read(Read), .RAM_write_en(RAM_write_en),
        .alu_add(alu_add), .GRA(GRA), .GRB(GRB), .GRC(GRC),
        .state(state), .halted(halted)
    );

    assign ctl = {PCout, ZLowout, MDRout, BAout, Cout, R_out,
                  MARin, MDRin, PCin, IRin, Yin, ZHighIn, ZLowIn, R_in,
                  IncPC, Read, RAM_write_en, alu_add, GRA, GRB, GRC};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        run = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        run = 1'b1;
        opcode = 5'b11111;
        tick();
        tests++;
        if (state !== 4'd0 || halted !== 1'b0 || ctl !== 21'h0) begin
            fails++;
            $display("FAIL reset: state=%0d halted=%b ctl=%h want 0/0/0",
                     state, halted, ctl);
        end
        clr = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (state !== 4'd0 || ctl !== 21'h0) begin
                fails++;
                $display("FAIL idle_hold: state=%0d ctl=%h want 0/0", state, ctl);
            end
        end
    endtask

    task automatic test_st();
        logic [20:0] exp_c [8];
        exp_c = '{C_T0, C_T1, C_T2, C_T3, C_T4, C_T5M, C_T6S, C_T7S};
        do_reset();
        opcode = 5'b00010;
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if (state !== 4'(i + 1) || ctl !== exp_c[i] || halted !== 1'b0) begin
                fails++;
                $display("FAIL st_step%0d: state=%0d ctl=%h want %0d/%h",
                         i, state, ctl, i + 1, exp_c[i]);
            end
        end
        tick();
        tests++;
        if (state !== 4'd1 || ctl !== C_T0) begin
            fails++;
            $display("FAIL st_next: state=%0d ctl=%h want 1/%h", state, ctl, C_T0);
        end
    endtask

    task automatic test_ld();
        logic [20:0] exp_c [8];
        exp_c = '{C_T0, C_T1, C_T2, C_T3, C_T4, C_T5M, C_T6L, C_T7L};
        do_reset();
        opcode = 5'b00000;
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if (state !== 4'(i + 1) || ctl !== exp_c[i]) begin
                fails++;
                $display("FAIL ld_step%0d: state=%0d ctl=%h want %0d/%h",
                         i, state, ctl, i + 1, exp_c[i]);
            end
        end
        tick();
        tests++;
        if (state !== 4'd1) begin
            fails++;
            $display("FAIL ld_next: state=%0d want 1", state);
        end
    endtask

    task automatic test_ldi();
        do_reset();
        opcode = 5'b00001;
        run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (state !== 4'd4 || ctl !== C_T3) begin
            fails++;
            $display("FAIL ldi_t3: state=%0d ctl=%h want 4/%h", state, ctl, C_T3);
        end
`ifdef CU_LDI_EN
        tick();
        tick();
        tests++;
        if (state !== 4'd6 || ctl !== C_T5I) begin
            fails++;
            $display("FAIL ldi_t5: state=%0d ctl=%h want 6/%h", state, ctl, C_T5I);
        end
        tick();
        tests++;
        if (state !== 4'd1 || ctl !== C_T0) begin
            fails++;
            $display("FAIL ldi_next: state=%0d ctl=%h want 1/%h", state, ctl, C_T0);
        end
`else
        tick();
        tests++;
        if (state !== 4'd15 || halted !== 1'b1 || ctl !== 21'h0) begin
            fails++;
            $display("FAIL ldi_trap: state=%0d halted=%b ctl=%h want 15/1/0",
                     state, halted, ctl);
        end
`endif
    endtask

    task automatic test_illegal();
        logic [4:0] ops [2];
        ops = '{5'b11111, 5'b00011};
        foreach (ops[k]) begin
            do_reset();
            opcode = ops[k];
            run = 1'b1;
            for (int i = 0; i < 5; i++) tick();
            tests++;
            if (state !== 4'd15 || halted !== 1'b1 || ctl !== 21'h0) begin
                fails++;
                $display("FAIL illegal_%0d: state=%0d halted=%b ctl=%h want 15/1/0",
                         k, state, halted, ctl);
            end
            for (int i = 0; i < 10; i++) begin
                tick();
                tests++;
                if (state !== 4'd15 || halted !== 1'b1 || ctl !== 21'h0) begin
                    fails++;
                    $display("FAIL halt_hold%0d: state=%0d halted=%b ctl=%h",
                             i, state, halted, ctl);
                end
            end
            clr = 1'b1;
            tick();
            clr = 1'b0;
            tests++;
            if (state !== 4'd0 || halted !== 1'b0 || ctl !== 21'h0) begin
                fails++;
                $display("FAIL halt_clr: state=%0d halted=%b ctl=%h want 0/0/0",
                         state, halted, ctl);
            end
        end
    endtask

    task automatic test_clr_mid();
        do_reset();
        opcode = 5'b00010;
        run = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        tests++;
        if (state !== 4'd7 || ctl !== C_T6S) begin
            fails++;
            $display("FAIL clr_mid_t6: state=%0d ctl=%h want 7/%h", state, ctl, C_T6S);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        run = 1'b0;
        tests++;
        if (state !== 4'd0 || ctl !== 21'h0) begin
            fails++;
            $display("FAIL clr_mid: state=%0d ctl=%h want 0/0", state, ctl);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (RAM_write_en !== 1'b0 || state !== 4'd0) begin
                fails++;
                $display("FAIL clr_mid_we%0d: we=%b state=%0d want 0/0",
                         i, RAM_write_en, state);
            end
        end
    endtask

    task automatic test_run_low();
        do_reset();
        opcode = 5'b00000;
        run = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        run = 1'b0;
        tick();
        tests++;
        if (state !== 4'd8 || ctl !== C_T7L) begin
            fails++;
            $display("FAIL run_low_t7: state=%0d ctl=%h want 8/%h", state, ctl, C_T7L);
        end
        tick();
        tests++;
        if (state !== 4'd0) begin
            fails++;
            $display("FAIL run_low_idle: state=%0d want 0", state);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (state !== 4'd0 || ctl !== 21'h0) begin
                fails++;
                $display("FAIL run_low_hold%0d: state=%0d ctl=%h", i, state, ctl);
            end
        end
        run = 1'b1;
        tick();
        tests++;
        if (state !== 4'd1 || ctl !== C_T0) begin
            fails++;
            $display("FAIL run_low_restart: state=%0d ctl=%h want 1/%h",
                     state, ctl, C_T0);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clr = 1'b0;
        run = 1'b0;
        opcode = 5'b00000;
        tick();
        test_reset();
        test_st();
        test_ld();
        test_ldi();
        test_illegal();
        test_clr_mid();
        test_run_low();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
